// File: rtl/display_scheduler.sv
// Owns a shared 4-digit multiplexed 7-segment display: scan timing with blanking,
// plus frame-aligned round-robin arbitration between N_REQ hex-value requesters.
module display_scheduler #(
  parameter int N_REQ        = 3,
  parameter int SCAN_PERIOD  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int DWELL_FRAMES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  data,
  output logic [N_REQ-1:0]     grant,
  output logic [3:0]           digit,
  output logic [3:0]           an,
  output logic                 frame_tick,
  output logic                 busy
);

  localparam int CW = $clog2(SCAN_PERIOD);
  localparam int IW = $clog2(N_REQ);
  localparam int DW = $clog2(DWELL_FRAMES + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_PERIOD - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [DW:0]   DWELL_LIM = (DW + 1)'(DWELL_FRAMES);
  localparam logic [IW-1:0] LAST_INIT = IW'(N_REQ - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [1:0]      idx;
  logic [IW-1:0]   owner, owner_n;
  logic [IW-1:0]   last_owner, last_n;
  logic [DW-1:0]   dwell, dwell_n;
  logic [DW:0]     dwell_inc;
  logic [15:0]     disp_value;
  logic [15:0]     slice [N_REQ];
  logic [N_REQ-1:0] owner_oh;
  logic            others;
  logic            fb;

  // First requester strictly after base, wrapping; base itself is checked last.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [IW-1:0]    base);
    logic [IW-1:0] pick;
    logic [IW-1:0] ci;
    pick = base;
    for (int k = N_REQ; k >= 1; k--) begin
      ci = IW'((int'(base) + k) % N_REQ);
      if (r[ci]) pick = ci;
    end
    return pick;
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) slice[i] = data[16*i +: 16];
  end

  assign fb         = (cnt == CNT_LAST) && (idx == 2'd3);
  assign frame_tick = fb;
  assign owner_oh   = N_REQ'(1) << owner;
  assign others     = |(req & ~owner_oh);
  assign dwell_inc  = {1'b0, dwell} + (DW + 1)'(1);
  assign grant      = (state == OWN) ? owner_oh : '0;
  assign busy       = |grant;

  // Arbitration only moves at the frame boundary so a frame never mixes sources.
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last_owner;
    dwell_n = dwell;
    if (fb) begin
      case (state)
        IDLE: begin
          if (|req) begin
            state_n = OWN;
            owner_n = rr_pick(req, last_owner);
            dwell_n = '0;
          end
        end
        OWN: begin
          if (!req[owner]) begin
            last_n = owner;
            if (|req) begin
              owner_n = rr_pick(req, owner);
              dwell_n = '0;
            end else begin
              state_n = IDLE;
            end
          end else if (dwell_inc >= DWELL_LIM && others) begin
            owner_n = rr_pick(req, owner);
            dwell_n = '0;
          end else if (dwell_inc <= DWELL_LIM) begin
            dwell_n = dwell_inc[DW-1:0];
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: all state here uses <= so every register samples pre-edge values;
  // a blocking = would let later statements see half-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      owner      <= '0;
      last_owner <= LAST_INIT;
      dwell      <= '0;
      disp_value <= '0;
      digit      <= '0;
      an         <= 4'b1111;
    end else begin
      cnt        <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      if (cnt == CNT_LAST) idx <= idx + 2'd1;
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_n;
      dwell      <= dwell_n;
      if (fb && state_n == OWN) disp_value <= slice[owner_n];
      digit      <= disp_value[{idx, 2'b00} +: 4];
      an         <= (state == IDLE || cnt < BLANK_END) ? 4'b1111 : ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: time-based reference model compared
// every cycle, plus directed stimulus with hand-computed literal expectations.
module tb_display_scheduler;

  localparam int N  = 3;
  localparam int SP = 8;
  localparam int BL = 2;
  localparam int DF = 2;
  localparam int FRAME = 4 * SP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [16*N-1:0] data = '0;
  logic [N-1:0]  grant;
  logic [3:0]    digit;
  logic [3:0]    an;
  logic          frame_tick;
  logic          busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  display_scheduler #(
    .N_REQ(N), .SCAN_PERIOD(SP), .BLANK_CYCLES(BL), .DWELL_FRAMES(DF)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .grant(grant),
    .digit(digit), .an(an), .frame_tick(frame_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: time since reset gives slot/prescaler; ownership decided per frame.
  int          m_t = 0;
  int          m_owner = -1;
  int          m_last = N - 1;
  int          m_dwell = 0;
  logic [15:0] m_disp = '0;
  logic [3:0]  exp_an = 4'hF;
  logic [3:0]  exp_digit = '0;
  bit          model_valid = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int base);
    for (int k = 1; k <= N; k++) begin
      if (r[(base + k) % N]) return (base + k) % N;
    end
    return base;
  endfunction

  always @(posedge clk) begin
    int pre, slot;
    if (rst) begin
      m_t = 0; m_owner = -1; m_last = N - 1; m_dwell = 0; m_disp = '0;
      exp_an = 4'hF; exp_digit = '0; model_valid = 1'b1;
    end else begin
      pre  = m_t % SP;
      slot = (m_t / SP) % 4;
      exp_digit = 4'((m_disp >> (4 * slot)) & 16'hF);
      exp_an    = (m_owner < 0 || pre < BL) ? 4'hF : 4'hF ^ 4'(1 << slot);
      if (m_t % FRAME == FRAME - 1) begin
        if (m_owner < 0) begin
          if (req != 0) begin m_owner = pick(req, m_last); m_dwell = 0; end
        end else if (!req[m_owner]) begin
          m_last = m_owner;
          if (req != 0) begin m_owner = pick(req, m_owner); m_dwell = 0; end
          else m_owner = -1;
        end else if (m_dwell + 1 >= DF && (req & ~(N'(1) << m_owner)) != 0) begin
          m_owner = pick(req, m_owner); m_dwell = 0;
        end else begin
          m_dwell = (m_dwell + 1 > DF) ? DF : m_dwell + 1;
        end
        if (m_owner >= 0) m_disp = 16'(data >> (16 * m_owner));
      end
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("grant", 16'(grant), (m_owner < 0) ? 16'h0 : 16'(1 << m_owner));
      check("busy", 16'(busy), 16'(m_owner >= 0));
      check("an", 16'(an), 16'(exp_an));
      check("digit", 16'(digit), 16'(exp_digit));
      check("frame_tick", 16'(frame_tick), 16'(m_t % FRAME == FRAME - 1));
    end
  end

  task automatic go_to(input int n);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc != n && guard < 5000);
    if (cyc != n) begin
      n_checks++;
      n_err++;
      $display("FAIL go_to: reached cycle %0d, wanted %0d", cyc, n);
    end
  endtask

  initial begin
    // Reset, idle for three frames
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_grant", 16'(grant), 16'h0);
    check("rst_an", 16'(an), 16'hF);
    check("rst_digit", 16'(digit), 16'h0);
    check("rst_tick", 16'(frame_tick), 16'h0);
    go_to(30);  check("tick30", 16'(frame_tick), 16'h0);
    go_to(31);  check("tick31", 16'(frame_tick), 16'h1);
                check("idle_an", 16'(an), 16'hF);
    go_to(63);  check("tick63", 16'(frame_tick), 16'h1);

    // Requester 1 asks mid-frame
    go_to(100); req = 3'b010; data[16 +: 16] = 16'hA5C3;
    go_to(127); check("pre_fb_grant", 16'(grant), 16'h0);
    go_to(128); check("grant1", 16'(grant), 16'h2);
                check("busy1", 16'(busy), 16'h1);
                check("an_fb", 16'(an), 16'hF);
    go_to(131); check("an_d0", 16'(an), 16'hE); check("dig_d0", 16'(digit), 16'h3);
    go_to(138); check("an_blank", 16'(an), 16'hF); check("dig_blank", 16'(digit), 16'hC);
    go_to(139); check("an_d1", 16'(an), 16'hD); check("dig_d1", 16'(digit), 16'hC);
    go_to(147); check("an_d2", 16'(an), 16'hB); check("dig_d2", 16'(digit), 16'h5);
    go_to(155); check("an_d3", 16'(an), 16'h7); check("dig_d3", 16'(digit), 16'hA);

    // Mid-frame data change is held off until the boundary
    go_to(170); data[16 +: 16] = 16'h1234;
    go_to(187); check("stale_an", 16'(an), 16'h7); check("stale_dig", 16'(digit), 16'hA);
    go_to(195); check("new_d0", 16'(digit), 16'h4);
    go_to(219); check("new_d3", 16'(digit), 16'h1);

    // Hand-over to requester 0, then release to idle
    go_to(230); data[0 +: 16] = 16'hBEEF; req = 3'b001;
    go_to(256); check("grant0", 16'(grant), 16'h1);
    go_to(270); req = 3'b000;
    go_to(283); check("hold_an", 16'(an), 16'h7); check("hold_dig", 16'(digit), 16'hB);
    go_to(288); check("rel_grant", 16'(grant), 16'h0); check("rel_busy", 16'(busy), 16'h0);
    go_to(291); check("rel_an", 16'(an), 16'hF); check("rel_dig", 16'(digit), 16'hF);
    go_to(300); req = 3'b001;
    go_to(319); check("regrant_pre", 16'(grant), 16'h0);
    go_to(320); check("regrant", 16'(grant), 16'h1);

    // Reset pulse at prescaler 5, digit 2 while owned
    go_to(341); rst = 1'b1;
    @(negedge clk);
    check("mid_rst_grant", 16'(grant), 16'h0);
    check("mid_rst_an", 16'(an), 16'hF);
    check("mid_rst_tick", 16'(frame_tick), 16'h0);
    rst = 1'b0;
    go_to(30);  check("mr_tick30", 16'(frame_tick), 16'h0);
    go_to(31);  check("mr_tick31", 16'(frame_tick), 16'h1);
    go_to(32);  check("mr_grant", 16'(grant), 16'h1);

    // All three requesting from reset: round-robin with a two-frame dwell
    go_to(40);
    req = 3'b111;
    data = {16'h3333, 16'h2222, 16'h1111};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    go_to(31);  check("rr31", 16'(grant), 16'h0);
    go_to(32);  check("rr32", 16'(grant), 16'h1);
    go_to(95);  check("rr95", 16'(grant), 16'h1);
    go_to(96);  check("rr96", 16'(grant), 16'h2);
    go_to(99);  check("rr99_an", 16'(an), 16'hE); check("rr99_dig", 16'(digit), 16'h2);
    go_to(159); check("rr159", 16'(grant), 16'h2);
    go_to(160); check("rr160", 16'(grant), 16'h4);
    go_to(163); check("rr163_dig", 16'(digit), 16'h3);
    go_to(223); check("rr223", 16'(grant), 16'h4);
    go_to(224); check("rr224", 16'(grant), 16'h1);
    go_to(240);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
